// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE decoder: FSM states, entry field layout, word geometry.
package rle_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ENTRY_W    = 16;
    localparam int unsigned CNT_LSB    = 0;
    localparam int unsigned VAL_LSB    = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        DECODE,
        FLUSH
    } state_t;

endpackage

// File: rtl/rle_byte_packer.sv
// Little-endian byte accumulator: gathers decoded bytes into 32-bit words, with a whole-word fill path.
module rle_byte_packer
    import rle_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic              i_fill,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [DATA_W-1:0] o_word_c,
    output logic              o_word_valid_c,
    output logic              o_flush_c,
    output logic [1:0]        o_pos
);

    logic [DATA_W-1:0] r_word;
    logic [1:0]        r_pos;
    logic [DATA_W-1:0] w_next;

    // Word as it stands after this cycle's byte (or fill) is merged in.
    always_comb begin
        w_next = r_word;
        if (i_fill) begin
            w_next = {WORD_BYTES{i_byte}};
        end else if (i_push) begin
            w_next[{r_pos, 3'b000} +: BYTE_W] = i_byte;
        end
    end

    assign o_word_c       = w_next;
    assign o_word_valid_c = i_fill || (i_push && (r_pos == 2'(WORD_BYTES - 1)));
    assign o_flush_c      = (r_pos != 2'd0);
    assign o_pos          = r_pos;

    // Completed or cleared words restart from zero so partial words leave upper bytes zeroed.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_word <= '0;
            r_pos  <= '0;
        end else if (i_clear || o_word_valid_c) begin
            r_word <= '0;
            r_pos  <= '0;
        end else if (i_push) begin
            r_word <= w_next;
            r_pos  <= r_pos + 2'd1;
        end
    end

endmodule

// File: rtl/rle_decode.sv
// Run-length decoder: reads {value,count} entries from SRAM and writes expanded bytes back through one port.
// Optional RLE_DECODE_FAST_FILL_EN emits a whole word per cycle when a run covers an aligned word.
module rle_decode
    import rle_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [31:0]       rle_size,
    input  logic [31:0]       message_addr,
    output logic [31:0]       message_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

`ifdef RLE_DECODE_FAST_FILL_EN
    localparam bit FAST_FILL = 1'b1;
`else
    localparam bit FAST_FILL = 1'b0;
`endif

    state_t              r_state,    w_state_d;
    logic [ADDR_W-1:0]   r_rd_ptr,   w_rd_ptr_d;
    logic [ADDR_W-1:0]   r_wr_ptr,   w_wr_ptr_d;
    logic [31:0]         r_rd_bytes, w_rd_bytes_d;
    logic [31:0]         r_rle_size, w_rle_size_d;
    logic [ENTRY_W-1:0]  r_upper,    w_upper_d;
    logic                r_half,     w_half_d;
    logic [BYTE_W-1:0]   r_run,      w_run_d;
    logic [BYTE_W-1:0]   r_value,    w_value_d;
    logic [31:0]         r_msize,    w_msize_d;
    logic                r_done,     w_done_d;
    logic                r_we,       w_we_d;
    logic [ADDR_W-1:0]   r_addr,     w_addr_d;
    logic [DATA_W-1:0]   r_wdata,    w_wdata_d;

    logic                w_pk_clear;
    logic                w_pk_push;
    logic                w_pk_fill;
    logic [DATA_W-1:0]   w_pk_word;
    logic                w_pk_word_valid;
    logic                w_pk_flush;
    logic [1:0]          w_pk_pos;
    logic                w_unused_addr_bits;

    assign w_unused_addr_bits = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W]};

    rle_byte_packer u_packer (
        .clk            (clk),
        .nreset         (nreset),
        .i_clear        (w_pk_clear),
        .i_push         (w_pk_push),
        .i_fill         (w_pk_fill),
        .i_byte         (r_value),
        .o_word_c       (w_pk_word),
        .o_word_valid_c (w_pk_word_valid),
        .o_flush_c      (w_pk_flush),
        .o_pos          (w_pk_pos)
    );

    // Next-state and next-register logic; port outputs are loaded one cycle ahead of use.
    always_comb begin
        w_state_d    = r_state;
        w_rd_ptr_d   = r_rd_ptr;
        w_wr_ptr_d   = r_wr_ptr;
        w_rd_bytes_d = r_rd_bytes;
        w_rle_size_d = r_rle_size;
        w_upper_d    = r_upper;
        w_half_d     = r_half;
        w_run_d      = r_run;
        w_value_d    = r_value;
        w_msize_d    = r_msize;
        w_done_d     = r_done;
        w_we_d       = 1'b0;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_pk_clear   = 1'b0;
        w_pk_push    = 1'b0;
        w_pk_fill    = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_rd_ptr_d   = rle_addr[ADDR_W-1:0];
                    w_wr_ptr_d   = message_addr[ADDR_W-1:0];
                    w_rd_bytes_d = '0;
                    w_rle_size_d = rle_size;
                    w_msize_d    = '0;
                    w_done_d     = 1'b0;
                    w_pk_clear   = 1'b1;
                    if (rle_size == 32'd0) begin
                        w_state_d = FLUSH;
                    end else begin
                        w_state_d = RD_ISSUE;
                        w_addr_d  = rle_addr[ADDR_W-1:0];
                    end
                end
            end

            RD_ISSUE: begin
                // A write occupying the port this cycle pushes the read out by one cycle.
                if (r_we) begin
                    w_addr_d = r_rd_ptr;
                end else begin
                    w_state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                w_upper_d    = port_A_data_out[ENTRY_W +: ENTRY_W];
                w_run_d      = port_A_data_out[CNT_LSB +: BYTE_W];
                w_value_d    = port_A_data_out[VAL_LSB +: BYTE_W];
                w_half_d     = 1'b0;
                w_rd_ptr_d   = r_rd_ptr + ADDR_W'(WORD_BYTES);
                w_rd_bytes_d = r_rd_bytes + 32'(WORD_BYTES);
                w_state_d    = DECODE;
            end

            DECODE: begin
                if (r_run != 8'd0) begin
                    if (FAST_FILL && (w_pk_pos == 2'd0) && (r_run >= 8'(WORD_BYTES))) begin
                        w_pk_fill = 1'b1;
                        w_run_d   = r_run - 8'(WORD_BYTES);
                        w_msize_d = r_msize + 32'(WORD_BYTES);
                    end else begin
                        w_pk_push = 1'b1;
                        w_run_d   = r_run - 8'd1;
                        w_msize_d = r_msize + 32'd1;
                    end
                    if (w_pk_word_valid) begin
                        w_we_d     = 1'b1;
                        w_addr_d   = r_wr_ptr;
                        w_wdata_d  = w_pk_word;
                        w_wr_ptr_d = r_wr_ptr + ADDR_W'(WORD_BYTES);
                    end
                end else if (!r_half) begin
                    w_half_d  = 1'b1;
                    w_run_d   = r_upper[CNT_LSB +: BYTE_W];
                    w_value_d = r_upper[VAL_LSB +: BYTE_W];
                end else if (r_rd_bytes < r_rle_size) begin
                    w_state_d = RD_ISSUE;
                    w_addr_d  = r_rd_ptr;
                end else begin
                    w_state_d = FLUSH;
                end
            end

            FLUSH: begin
                if (w_pk_flush) begin
                    w_we_d     = 1'b1;
                    w_addr_d   = r_wr_ptr;
                    w_wdata_d  = w_pk_word;
                    w_wr_ptr_d = r_wr_ptr + ADDR_W'(WORD_BYTES);
                end
                w_pk_clear = 1'b1;
                w_done_d   = 1'b1;
                w_state_d  = IDLE;
            end

            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= IDLE;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_bytes <= '0;
            r_rle_size <= '0;
            r_upper    <= '0;
            r_half     <= 1'b0;
            r_run      <= '0;
            r_value    <= '0;
            r_msize    <= '0;
            r_done     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_bytes <= w_rd_bytes_d;
            r_rle_size <= w_rle_size_d;
            r_upper    <= w_upper_d;
            r_half     <= w_half_d;
            r_run      <= w_run_d;
            r_value    <= w_value_d;
            r_msize    <= w_msize_d;
            r_done     <= w_done_d;
            r_we       <= w_we_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
        end
    end

    assign message_size   = r_msize;
    assign done           = r_done;
    assign port_A_clk     = clk;
    assign port_A_addr    = r_addr;
    assign port_A_we      = r_we;
    assign port_A_data_in = r_wdata;

endmodule

// File: tb/tb_rle_decode.sv
// Bench for rle_decode: SRAM model, queue-based expansion reference, directed and random streams.
module tb_rle_decode;

    localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;
    localparam int          LIMIT    = 4000;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [31:0] rle_addr;
    logic [31:0] rle_size;
    logic [31:0] message_addr;
    logic [31:0] message_size;
    logic        done;
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic        port_A_we;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;

    logic [31:0] mem [0:16383];
    logic        tb_ld = 1'b0;
    logic [13:0] tb_ld_idx = '0;
    logic [31:0] tb_ld_data = '0;
    int unsigned wr_count = 0;

    logic [31:0] rle_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rle_decode dut (
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .message_addr    (message_addr),
        .message_size    (message_size),
        .done            (done),
        .port_A_clk      (port_A_clk),
        .port_A_addr     (port_A_addr),
        .port_A_we       (port_A_we),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out)
    );

    // Synchronous single-port SRAM, byte-addressed, read data one cycle after the address.
    always @(posedge port_A_clk) begin
        if (tb_ld) mem[tb_ld_idx] <= tb_ld_data;
        if (port_A_we) begin
            mem[port_A_addr[15:2]] <= port_A_data_in;
            wr_count <= wr_count + 1;
        end
        port_A_data_out <= mem[port_A_addr[15:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [13:0] idx, input logic [31:0] d);
        @(negedge clk);
        tb_ld = 1'b1; tb_ld_idx = idx; tb_ld_data = d;
        @(posedge clk); #1;
        tb_ld = 1'b0;
    endtask

    // Expands rle_q from ra into ma and checks size, write count, every word and the word past the end.
    task automatic run_decode(input logic [31:0] ra, input logic [31:0] ma, input string tag,
                              input bit poke_busy, output int cyc);
        logic [7:0]  bq[$];
        logic [31:0] e;
        logic [31:0] w;
        int          n;
        int          nw;
        int unsigned wc0;
        foreach (rle_q[i]) begin
            for (int h = 0; h < 2; h++) begin
                e = rle_q[i] >> (16 * h);
                for (int k = 0; k < int'(e[7:0]); k++) bq.push_back(e[15:8]);
            end
        end
        n  = bq.size();
        nw = (n + 3) / 4;
        foreach (rle_q[i]) load(14'(ra[15:2] + 14'(i)), rle_q[i]);
        for (int i = 0; i <= nw; i++) load(14'(ma[15:2] + 14'(i)), SENTINEL);
        wc0 = wr_count;
        @(negedge clk);
        start = 1'b1; rle_addr = ra; rle_size = 32'(4 * rle_q.size()); message_addr = ma;
        @(posedge clk); #1;
        check({tag, " done_drop"}, 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        if (poke_busy) begin
            repeat (2) @(negedge clk);
            start = 1'b1; rle_size = 32'd0; message_addr = 32'h0000_F000;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 1;
        while (!done && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        @(posedge clk); #1;
        check({tag, " msize"}, message_size, 32'(n));
        check({tag, " writes"}, 32'(wr_count - wc0), 32'(nw));
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int b = 0; b < 4; b++) if (4 * i + b < n) w[8*b +: 8] = bq[4 * i + b];
            check($sformatf("%s word%0d", tag, i), mem[14'(ma[15:2] + 14'(i))], w);
        end
        check({tag, " past_end"}, mem[14'(ma[15:2] + 14'(nw))], SENTINEL);
    endtask

    initial begin
        int          cyc;
        int unsigned wc0;
        logic [7:0]  c0, c1;
        nreset = 1'b0; start = 1'b0;
        rle_addr = '0; rle_size = '0; message_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst we",    32'(port_A_we),   32'd0);
        check("rst addr",  32'(port_A_addr), 32'd0);
        check("rst wdata", port_A_data_in,   32'd0);
        check("rst msize", message_size,     32'd0);
        check("rst done",  32'(done),        32'd0);
        @(negedge clk);
        nreset = 1'b1;

        rle_q = '{32'h0000_4103};
        run_decode(32'h1000, 32'h4000, "single", 1'b0, cyc);
        check("single const", mem[14'h1000], 32'h0041_4141);

        rle_q = '{32'h4202_4103};
        run_decode(32'h1100, 32'h4100, "two_runs_busy", 1'b1, cyc);
        check("two_runs w1", mem[14'(32'h4104 >> 2)], 32'h0000_0042);

        rle_q = '{32'h0000_5504, 32'h0000_6604};
        run_decode(32'h1200, 32'h4200, "aligned", 1'b0, cyc);

        rle_q = '{32'h0000_7AFF};
        run_decode(32'h1300, 32'h5000, "long", 1'b0, cyc);
        check("long last", mem[14'(32'h50FC >> 2)], 32'h007A_7A7A);
        $display("long run decode cycles: %0d", cyc);

        // Zero-length stream: no writes, done two cycles after start.
        wc0 = wr_count;
        @(negedge clk);
        start = 1'b1; rle_size = 32'd0; rle_addr = 32'h1400; message_addr = 32'h6000;
        @(posedge clk); #1;
        check("empty done+1", 32'(done), 32'd0);
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        check("empty done+2", 32'(done), 32'd1);
        check("empty msize", message_size, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("empty writes", 32'(wr_count - wc0), 32'd0);

        // Reset in the middle of a long run.
        load(14'(32'h1500 >> 2), 32'h0000_33FF);
        @(negedge clk);
        start = 1'b1; rle_addr = 32'h1500; rle_size = 32'd4; message_addr = 32'h7000;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        check("midrst we",    32'(port_A_we),   32'd0);
        check("midrst addr",  32'(port_A_addr), 32'd0);
        check("midrst wdata", port_A_data_in,   32'd0);
        check("midrst msize", message_size,     32'd0);
        check("midrst done",  32'(done),        32'd0);
        wc0 = wr_count;
        repeat (4) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst nowrite", 32'(wr_count - wc0), 32'd0);
        check("midrst idle done", 32'(done), 32'd0);

        rle_q = '{32'h0000_4103};
        run_decode(32'h1000, 32'h7400, "restart", 1'b0, cyc);

        // Random streams against the expansion model.
        for (int t = 0; t < 8; t++) begin
            rle_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                c0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
                c1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
                rle_q.push_back({8'($urandom), c1, 8'($urandom), c0});
            end
            run_decode(32'h2000 + 32'(16 * t), 32'h8000 + 32'(2048 * t),
                       $sformatf("rand%0d", t), 1'b0, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
